gc_send: RTL

- Transmitter for the GameCube controller single-wire, open-drain data line; the other direction of the existing receiver.
- Serialises a command (8-bit init/probe or 24-bit poll, e.g. 0x400300) MSB first, then a stop bit.
- Drives the line only low (open-drain enable); the external pull-up supplies the high level.
- Provides the `send` qualifier consumed by the receiver, so the receiver ignores the host's own edges and re-arms its bit count.

---
 rtl/gc_send.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/gc_send.sv
// GameCube controller line transmitter: serialises a command MSB first plus
// a stop bit on the open-drain data line, then holds off for the response.
module gc_send #(
  parameter int CYCLES_PER_US = 100,
  parameter int RELEASE_HOLD  = 20,
  parameter int GAP_CYCLES    = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] cmd,
  input  logic [4:0]  cmd_bits,
  output logic        data_oe,
  output logic        send,
  output logic        busy,
  output logic        done
);

  localparam int U3 = 3 * CYCLES_PER_US;
  localparam int M1 = (U3 > RELEASE_HOLD) ? U3 : RELEASE_HOLD;
  localparam int MAXC = (M1 > GAP_CYCLES) ? M1 : GAP_CYCLES;
  localparam int CW = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

  localparam logic [CW-1:0] C1 = CW'(CYCLES_PER_US - 1);
  localparam logic [CW-1:0] C3 = CW'(U3 - 1);
  localparam logic [CW-1:0] CH = CW'(RELEASE_HOLD - 1);
  localparam logic [CW-1:0] CG = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    BIT_LOW,
    BIT_HIGH,
    STOP_LOW,
    HOLD,
    GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [23:0]   shreg;
  logic [4:0]    left;
  logic [4:0]    n_clamp;
  logic          last_bit;

  assign n_clamp  = (cmd_bits > 5'd24) ? 5'd24 : cmd_bits;
  assign last_bit = (left == 5'd1);

  // A 1 bit is short-low/long-high, a 0 bit the reverse.
  function automatic logic [CW-1:0] low_len(input logic b);
    return b ? C1 : C3;
  endfunction

  function automatic logic [CW-1:0] high_len(input logic b);
    return b ? C3 : C1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      left    <= '0;
      data_oe <= 1'b0;
      send    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg   <= cmd;
            left    <= n_clamp;
            busy    <= 1'b1;
            send    <= 1'b1;
            data_oe <= 1'b1;
            if (n_clamp == 5'd0) begin
              state <= STOP_LOW;
              cnt   <= C1;
            end else begin
              state <= BIT_LOW;
              cnt   <= low_len(cmd[23]);
            end
          end
        end
        BIT_LOW: begin
          if (cnt == '0) begin
            state   <= BIT_HIGH;
            data_oe <= 1'b0;
            cnt     <= high_len(shreg[23]);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BIT_HIGH: begin
          if (cnt == '0) begin
            shreg   <= {shreg[22:0], 1'b0};
            left    <= left - 5'd1;
            data_oe <= 1'b1;
            if (last_bit) begin
              state <= STOP_LOW;
              cnt   <= C1;
            end else begin
              state <= BIT_LOW;
              cnt   <= low_len(shreg[22]);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP_LOW: begin
          if (cnt == '0) begin
            state   <= HOLD;
            data_oe <= 1'b0;
            cnt     <= CH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          // Keep send up while the pull-up and receiver sync settle.
          if (cnt == '0) begin
            state <= GAP;
            send  <= 1'b0;
            done  <= 1'b1;
            cnt   <= CG;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          data_oe <= 1'b0;
          send    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
